tiny_nn_cmd_seq: RTL and testbench

TINY_NN_CMD_SEQ -- requirements
Module: tiny_nn_cmd_seq

---
 rtl/tiny_nn_cmd_seq.sv | 141 ++++++++++++++
 tb/tb_tiny_nn_cmd_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_nn_cmd_seq.sv
// rtl/tiny_nn_cmd_seq.sv - command sequencer: header, parameter words, data words, flush drain
// Emits one registered 16-bit word per cycle to the core; slots with no valid input carry IDLE_WORD.
module tiny_nn_cmd_seq #(
    parameter int          PARAM_WORDS  = 8,
    parameter int          FLUSH_CYCLES = 16,
    parameter logic [15:0] IDLE_WORD    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [11:0] cmd_len_i,
    input  logic [7:0]  cmd_nwords_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [15:0] word_i,
    output logic [15:0] data_o,
    output logic        busy_o,
    output logic        underrun_o
);

    localparam int MAX_PF = (PARAM_WORDS > FLUSH_CYCLES) ? PARAM_WORDS : FLUSH_CYCLES;
    localparam int MAXC   = (MAX_PF > 255) ? MAX_PF : 255;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PARAM = 3'd2,
        S_DATA  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [15:0]  r_data;
    logic [15:0]  w_data_next;
    logic         r_underrun;
    logic         w_underrun_next;
    logic         w_accept;
    logic [3:0]   r_op;
    logic [11:0]  r_len;
    logic [7:0]   r_nwords;
    logic         w_last;

    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_data     <= IDLE_WORD;
            r_underrun <= 1'b0;
            r_op       <= '0;
            r_len      <= '0;
            r_nwords   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_data     <= w_data_next;
            r_underrun <= w_underrun_next;
            if (w_accept) begin
                r_op     <= cmd_op_i;
                r_len    <= cmd_len_i;
                r_nwords <= cmd_nwords_i;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt;
        w_data_next     = IDLE_WORD;
        w_underrun_next = r_underrun;
        w_accept        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept        = 1'b1;
                    w_underrun_next = 1'b0;
                    w_next_state    = S_HDR;
                end
            end
            S_HDR: begin
                w_data_next = {r_op, r_len};
                if (PARAM_WORDS > 0) begin
                    w_next_state = S_PARAM;
                    w_cnt_next   = CW'(PARAM_WORDS);
                end else if (r_nwords != 8'd0) begin
                    w_next_state = S_DATA;
                    w_cnt_next   = CW'(r_nwords);
                end else if (FLUSH_CYCLES > 0) begin
                    w_next_state = S_FLUSH;
                    w_cnt_next   = CW'(FLUSH_CYCLES);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_PARAM, S_DATA: begin
                // An empty slot is still consumed so the core sees a fixed-length phase.
                if (word_valid_i) begin
                    w_data_next = word_i;
                end else begin
                    w_underrun_next = 1'b1;
                end
                w_cnt_next = r_cnt - CW'(1);
                if (w_last) begin
                    if (r_state == S_PARAM && r_nwords != 8'd0) begin
                        w_next_state = S_DATA;
                        w_cnt_next   = CW'(r_nwords);
                    end else if (FLUSH_CYCLES > 0) begin
                        w_next_state = S_FLUSH;
                        w_cnt_next   = CW'(FLUSH_CYCLES);
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                w_cnt_next = r_cnt - CW'(1);
                if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign cmd_ready_o  = (r_state == S_IDLE);
    assign word_ready_o = (r_state == S_PARAM) || (r_state == S_DATA);
    assign busy_o       = (r_state != S_IDLE);
    assign data_o       = r_data;
    assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_tiny_nn_cmd_seq.sv
// tb/tb_tiny_nn_cmd_seq.sv - directed self-checking bench for tiny_nn_cmd_seq
module tb_tiny_nn_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        c0_valid;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_len;
    logic [7:0]  cmd_nwords;
    logic        word_valid;
    logic [15:0] word_in;

    logic        cmd_ready, word_ready, busy, underrun;
    logic [15:0] data_out;
    logic        d0_cmd_ready, d0_word_ready, d0_busy, d0_underrun;
    logic [15:0] d0_data;

    int n_checks = 0;
    int n_err    = 0;

    tiny_nn_cmd_seq u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .cmd_nwords_i (cmd_nwords),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .word_i       (word_in),
        .data_o       (data_out),
        .busy_o       (busy),
        .underrun_o   (underrun)
    );

    tiny_nn_cmd_seq #(.PARAM_WORDS(0)) u_dut_np (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (c0_valid),
        .cmd_ready_o  (d0_cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .cmd_nwords_i (cmd_nwords),
        .word_valid_i (word_valid),
        .word_ready_o (d0_word_ready),
        .word_i       (word_in),
        .data_o       (d0_data),
        .busy_o       (d0_busy),
        .underrun_o   (d0_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full command on the default instance; bad < 0 means every data word is valid.
    task automatic run_cmd(input logic [3:0] op, input logic [11:0] len, input logic [7:0] nw,
                           input int bad, input logic exp_ur);
        int nbusy;
        nbusy      = 0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_len    = len;
        cmd_nwords = nw;
        step();
        cmd_valid  = 1'b0;
        cmd_op     = ~op;
        cmd_len    = ~len;
        cmd_nwords = 8'd3;
        chk("accept_busy", {15'd0, busy}, 16'd1);
        chk("accept_ready", {15'd0, cmd_ready}, 16'd0);
        chk("accept_ur_clr", {15'd0, underrun}, 16'd0);
        chk("hdr_wready", {15'd0, word_ready}, 16'd0);
        nbusy += int'(busy);
        step();
        nbusy += int'(busy);
        chk("header", data_out, {op, len});
        for (int p = 0; p < 8; p++) begin
            chk("param_wready", {15'd0, word_ready}, 16'd1);
            word_valid = 1'b1;
            word_in    = 16'h3f00;
            step();
            nbusy += int'(busy);
            chk("param_word", data_out, 16'h3f00);
        end
        for (int d = 0; d < int'(nw); d++) begin
            chk("data_wready", {15'd0, word_ready}, 16'd1);
            word_valid = (d != bad);
            word_in    = 16'hA000 + 16'(d);
            step();
            nbusy += int'(busy);
            chk("data_word", data_out, (d == bad) ? 16'h0000 : 16'hA000 + 16'(d));
            if (bad >= 0 && d >= bad) chk("underrun_held", {15'd0, underrun}, 16'd1);
        end
        word_valid = 1'b0;
        word_in    = 16'hFFFF;
        for (int f = 0; f < 16; f++) begin
            chk("flush_wready", {15'd0, word_ready}, 16'd0);
            step();
            nbusy += int'(busy);
            chk("flush_word", data_out, 16'h0000);
        end
        chk("end_busy", {15'd0, busy}, 16'd0);
        chk("end_ready", {15'd0, cmd_ready}, 16'd1);
        chk("end_underrun", {15'd0, underrun}, {15'd0, exp_ur});
        chk("busy_cycles", 16'(nbusy), 16'(1 + 8 + int'(nw) + 16));
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        c0_valid   = 1'b0;
        cmd_op     = '0;
        cmd_len    = '0;
        cmd_nwords = '0;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_out, 16'h0000);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_word_ready", {15'd0, word_ready}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_underrun", {15'd0, underrun}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic command with all words valid; accepted on the first edge after reset.
        run_cmd(4'h1, 12'd32, 8'd16, -1, 1'b0);

        // Underrun on the third data word, then a clean command clears the flag.
        run_cmd(4'h1, 12'd32, 8'd16, 2, 1'b1);
        chk("ur_idle_hold", {15'd0, underrun}, 16'd1);
        run_cmd(4'h3, 12'h0ab, 8'd2, -1, 1'b0);

        // No parameter phase and no data phase on the PARAM_WORDS=0 instance.
        c0_valid   = 1'b1;
        cmd_op     = 4'h7;
        cmd_len    = 12'h123;
        cmd_nwords = 8'd0;
        step();
        c0_valid = 1'b0;
        chk("np_busy", {15'd0, d0_busy}, 16'd1);
        chk("np_hdr_wready", {15'd0, d0_word_ready}, 16'd0);
        step();
        chk("np_header", d0_data, 16'h7123);
        for (int f = 0; f < 16; f++) begin
            chk("np_flush_wready", {15'd0, d0_word_ready}, 16'd0);
            chk("np_flush_busy", {15'd0, d0_busy}, 16'd1);
            step();
            chk("np_flush_word", d0_data, 16'h0000);
        end
        chk("np_end_busy", {15'd0, d0_busy}, 16'd0);

        // Reset during DATA aborts at once; the next command starts from its header.
        cmd_valid  = 1'b1;
        cmd_op     = 4'h5;
        cmd_len    = 12'h010;
        cmd_nwords = 8'd16;
        step();
        cmd_valid  = 1'b0;
        word_valid = 1'b1;
        word_in    = 16'h5555;
        repeat (1 + 8 + 3) step();
        chk("pre_rst_data", data_out, 16'h5555);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", data_out, 16'h0000);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("midrst_wready", {15'd0, word_ready}, 16'd0);
        word_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(4'h9, 12'h0ff, 8'd1, -1, 1'b0);

        // cmd_valid held high: header-to-header spacing is HDR+PARAM+DATA+FLUSH+one IDLE cycle.
        cmd_valid  = 1'b1;
        cmd_op     = 4'h2;
        cmd_len    = 12'h005;
        cmd_nwords = 8'd4;
        word_valid = 1'b1;
        word_in    = 16'h0001;
        k = 0;
        while (data_out !== 16'h2005 && k < 10) begin
            step();
            k++;
        end
        chk("first_hdr_seen", {15'd0, (data_out === 16'h2005)}, 16'd1);
        k = 0;
        do begin
            step();
            k++;
        end while (data_out !== 16'h2005 && k < 100);
        chk("hdr_period", 16'(k), 16'(1 + 8 + 4 + 16 + 1));
        cmd_valid = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 100) begin
            step();
            k++;
        end
        chk("drain_idle", {15'd0, busy}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
